risc16_mmio: RTL and testbench

Memory-mapped peripheral unit on the risc16 CPU data bus. It sits downstream of the CPU in parallel with data RAM and decodes a small I/O window. The window holds:
- the 24-bit LED register,
- a free-running timer with a compare flag,
- a FIFO-buffered 8N1 UART transmitter.

It asserts `hit` so the RAM model suppresses writes and muxes `rdata` onto `din` for addresses in the window.

---
 rtl/risc16_mmio_if.sv | 20 ++
 rtl/risc16_mmio.sv | 212 +++++++++++++++++++++
 tb/tb_risc16_mmio.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_mmio_if.sv
// CPU data-bus view of the risc16 MMIO window.
// The CPU drives address, write data and strobes; the peripheral returns read data and the window hit.
interface risc16_mmio_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        oe;
  logic        we;
  logic [15:0] rdata;
  logic        hit;

  modport master (
    output addr, wdata, oe, we,
    input  rdata, hit
  );

  modport slave (
    input  addr, wdata, oe, we,
    output rdata, hit
  );
endinterface

// File: rtl/risc16_mmio.sv
// risc16 MMIO block: 24-bit LED register, free-running timer with sticky compare flag, FIFO-fed 8N1 UART TX.
// The UART is only built when RISC16_UART_EN is defined; otherwise TXDATA is not decoded and uart_tx idles high.
module risc16_mmio #(
  parameter logic [15:0] BASE_ADDR     = 16'h0200,
  parameter int          CLKS_PER_BIT  = 217,
  parameter int          TX_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  risc16_mmio_if.slave       bus,
  output logic [23:0]        led,
  output logic               uart_tx
);

  localparam logic [2:0] W_LED_LO = 3'd0;
  localparam logic [2:0] W_LED_HI = 3'd1;
  localparam logic [2:0] W_TIMER  = 3'd2;
  localparam logic [2:0] W_CMP    = 3'd3;
  localparam logic [2:0] W_STATUS = 3'd4;
  localparam logic [2:0] W_TXDATA = 3'd5;

  logic        in_window;
  logic [2:0]  word;
  logic        tx_decoded;
  logic        hit_c;
  logic        wr;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_busy;
  logic [15:0] rd_mux;

  // addr[0] is ignored so odd byte addresses alias their even word.
  assign in_window = (bus.addr[15:4] == BASE_ADDR[15:4]);
  assign word      = bus.addr[3:1];
  assign hit_c     = in_window && ((word <= W_STATUS) || tx_decoded);
  assign wr        = bus.we && hit_c;
  assign bus.hit   = hit_c;

  logic [23:0] led_q, led_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cmp_q, cmp_d;
  logic        match_q, match_d;

  always_comb begin
    led_d   = led_q;
    timer_d = timer_q + 16'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (wr) begin
      case (word)
        W_LED_LO: led_d[15:0]  = bus.wdata;
        W_LED_HI: led_d[23:16] = bus.wdata[7:0];
        W_TIMER:  timer_d      = 16'h0000;
        W_CMP:    cmp_d        = bus.wdata;
        W_STATUS: if (bus.wdata[0]) match_d = 1'b0;
        default:  ;
      endcase
    end
    // A compare hit overrides a clear landing in the same cycle.
    if (timer_q == cmp_q) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      timer_q <= '0;
      cmp_q   <= 16'hFFFF;
      match_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (word)
      W_LED_LO: rd_mux = led_q[15:0];
      W_LED_HI: rd_mux = {8'h00, led_q[23:16]};
      W_TIMER:  rd_mux = timer_q;
      W_CMP:    rd_mux = cmp_q;
      W_STATUS: rd_mux = {12'h000, tx_busy, tx_empty, tx_full, match_q};
      default:  rd_mux = 16'h0000;
    endcase
  end

  assign bus.rdata = hit_c ? rd_mux : 16'h0000;
  assign led       = led_q;

`ifdef RISC16_UART_EN
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  tx_state_t     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  assign tx_decoded = (word == W_TXDATA);
  assign tx_full    = (count_q == DEPTH_C);
  assign tx_empty   = (count_q == '0);
  assign tx_busy    = (state_q != TX_IDLE);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO is dropped even when a pop coincides.
  assign push       = wr && (word == W_TXDATA) && !tx_full;
  assign pop        = (state_q == TX_IDLE) && !tx_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // baud_q counts cycles within the current bit; the line register tx_q changes only on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            shift_q <= fifo_mem[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = tx_q;
`else
  assign tx_decoded = 1'b0;
  assign tx_full    = 1'b0;
  assign tx_empty   = 1'b1;
  assign tx_busy    = 1'b0;
  assign uart_tx    = 1'b1;
`endif

  // Read strobe, byte-select bit and UART sizing do not affect this window's behaviour in every build.
  logic unused_cfg;
  assign unused_cfg = ^{bus.oe, bus.addr[0], CLKS_PER_BIT[0], TX_FIFO_DEPTH[0]};

endmodule

// File: tb/tb_risc16_mmio.sv
// Self-checking bench for risc16_mmio: randomized register traffic against a behavioural model,
// plus UART frame / FIFO / reset scenarios when RISC16_UART_EN is defined.
module tb_risc16_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RISC16_UART_EN
  localparam bit UART_ON = 1'b1;
`else
  localparam bit UART_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] led;
  logic        uart_tx;

  risc16_mmio_if bus ();

  risc16_mmio #(
    .BASE_ADDR    (16'h0200),
    .CLKS_PER_BIT (CPB),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .led    (led),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit tx_log[$];

  logic [23:0] m_led;
  logic [15:0] m_timer;
  logic [15:0] m_cmp;
  logic        m_match;

  function automatic bit exp_hit(input logic [15:0] a);
    logic [2:0] w;
    w = a[3:1];
    return (a[15:4] == 12'h020) && ((w <= 3'd4) || (UART_ON && (w == 3'd5)));
  endfunction

  // Expected read data assuming the transmitter is idle with an empty FIFO.
  function automatic logic [15:0] exp_read(input logic [15:0] a);
    if (!exp_hit(a)) return 16'h0000;
    case (a[3:1])
      3'd0: return m_led[15:0];
      3'd1: return {8'h00, m_led[23:16]};
      3'd2: return m_timer;
      3'd3: return m_cmp;
      3'd4: return {12'h000, 3'b010, m_match};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] a, input logic [15:0] w, input bit we_i, input bit r);
    bit   wr_i;
    logic nm;
    if (r) begin
      m_led = '0; m_timer = '0; m_cmp = 16'hFFFF; m_match = 1'b0;
      return;
    end
    wr_i = we_i && exp_hit(a);
    if (m_timer == m_cmp) nm = 1'b1;
    else if (wr_i && a[3:1] == 3'd4 && w[0]) nm = 1'b0;
    else nm = m_match;
    if (wr_i && a[3:1] == 3'd2) m_timer = 16'h0000;
    else m_timer = m_timer + 16'd1;
    if (wr_i && a[3:1] == 3'd0) m_led[15:0] = w;
    if (wr_i && a[3:1] == 3'd1) m_led[23:16] = w[7:0];
    if (wr_i && a[3:1] == 3'd3) m_cmp = w;
    m_match = nm;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic [15:0] w, input bit we_i);
    bus.addr  = a;
    bus.wdata = w;
    bus.we    = we_i;
    bus.oe    = !we_i;
    #1;
  endtask

  task automatic tick();
    logic [15:0] a, w;
    bit we_i, r;
    a = bus.addr; w = bus.wdata; we_i = bus.we; r = rst;
    @(posedge clk);
    model_step(a, w, we_i, r);
    cyc++;
    #1;
    tx_log.push_back(uart_tx);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] w);
    set_bus(a, w, 1'b1);
    tick();
    set_bus(16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_bus(16'h0204, 16'h0000, 1'b0);
    tick();
    tick();
    checks++;
    if (led !== 24'h0) begin errors++; $display("FAIL reset_led got %h exp %h", led, 24'h0); end
    checks++;
    if (bus.rdata !== 16'h0000 || bus.hit !== 1'b1) begin
      errors++; $display("FAIL reset_timer got %h hit %b exp 0000 hit 1", bus.rdata, bus.hit);
    end
    set_bus(16'h0206, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata !== 16'hFFFF) begin errors++; $display("FAIL reset_cmp got %h exp FFFF", bus.rdata); end
    set_bus(16'h0208, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata !== 16'h0004) begin errors++; $display("FAIL reset_status got %h exp 0004", bus.rdata); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b exp 1", uart_tx); end
    rst = 1'b0;
    tick();
    $display("reset: released at cycle %0d", cyc);
  endtask

  task automatic test_led();
    set_bus(16'h0200, 16'hBEEF, 1'b1);
    checks++;
    if (bus.hit !== 1'b1) begin errors++; $display("FAIL led_lo_hit got %b exp 1", bus.hit); end
    tick();
    set_bus(16'h0203, 16'h12A5, 1'b1);
    checks++;
    if (bus.hit !== 1'b1) begin errors++; $display("FAIL led_hi_hit got %b exp 1", bus.hit); end
    tick();
    set_bus(16'h0202, 16'h0000, 1'b0);
    checks++;
    if (led !== 24'hA5BEEF) begin errors++; $display("FAIL led_value got %h exp A5BEEF", led); end
    checks++;
    if (bus.rdata !== 16'h00A5 || bus.hit !== 1'b1) begin
      errors++; $display("FAIL led_hi_read got %h hit %b exp 00A5 hit 1", bus.rdata, bus.hit);
    end
    $display("led: led=%h read_hi=%h", led, bus.rdata);
    tick();
  endtask

  task automatic test_out_of_window();
    logic [15:0] addrs [3];
    logic [15:0] w;
    addrs[0] = 16'h020C; addrs[1] = 16'h020E; addrs[2] = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      set_bus(addrs[i], w, 1'b1);
      checks++;
      if (bus.hit !== 1'b0 || bus.rdata !== 16'h0000) begin
        errors++; $display("FAIL oow_decode addr %h got hit %b rdata %h exp hit 0 rdata 0000", addrs[i], bus.hit, bus.rdata);
      end
      tick();
      $display("oow: write %h to %h hit=%b", w, addrs[i], bus.hit);
    end
    set_bus(16'h0000, 16'h0000, 1'b0);
    checks++;
    if (led !== m_led) begin errors++; $display("FAIL oow_led got %h exp %h", led, m_led); end
    set_bus(16'h0206, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata !== m_cmp) begin errors++; $display("FAIL oow_cmp got %h exp %h", bus.rdata, m_cmp); end
    tick();
  endtask

  task automatic test_random_regs();
    logic [15:0] a, w;
    bit we_i;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) a = 16'h0200 + 16'($urandom_range(0, 15));
      else a = 16'($urandom);
      w    = 16'($urandom);
      we_i = bit'($urandom_range(0, 1));
      if (UART_ON && exp_hit(a) && a[3:1] == 3'd5) we_i = 1'b0;
      set_bus(a, w, we_i);
      checks++;
      if (bus.hit !== exp_hit(a) || bus.rdata !== exp_read(a) || led !== m_led) begin
        errors++;
        $display("FAIL rand_access addr %h got hit %b rdata %h led %h exp hit %b rdata %h led %h",
                 a, bus.hit, bus.rdata, led, exp_hit(a), exp_read(a), m_led);
      end
      $display("rand: n=%0d addr=%h we=%b wdata=%h rdata=%h", n, a, we_i, w, bus.rdata);
      tick();
    end
    set_bus(16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_timer_match();
    bit seen;
    int dut_n, mod_n;
    bus_write(16'h0206, 16'h0010);
    bus_write(16'h0204, 16'($urandom));
    bus_write(16'h0208, 16'h0001);
    seen = 1'b0;
    set_bus(16'h0208, 16'h0000, 1'b0);
    for (int n = 0; n < 16 && !seen; n++) begin
      tick();
      checks++;
      if (bus.rdata !== exp_read(16'h0208)) begin
        errors++; $display("FAIL match_rise cycle %0d got %h exp %h", n, bus.rdata, exp_read(16'h0208));
      end
      seen = bus.rdata[0];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL match_within_17 got 0 exp 1"); end
    set_bus(16'h0208, 16'h0001, 1'b1);
    tick();
    set_bus(16'h0208, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata[0] !== 1'b0) begin errors++; $display("FAIL match_clear got %b exp 0", bus.rdata[0]); end
    dut_n = 0;
    mod_n = 0;
    for (int n = 1; n <= 70000 && (dut_n == 0 || mod_n == 0); n++) begin
      tick();
      if (dut_n == 0 && bus.rdata[0] === 1'b1) dut_n = n;
      if (mod_n == 0 && m_match) mod_n = n;
    end
    checks++;
    if (dut_n == 0 || dut_n != mod_n) begin
      errors++; $display("FAIL match_wrap cycles got %0d exp %0d", dut_n, mod_n);
    end
    $display("timer: match re-set after %0d cycles", dut_n);
    bus_write(16'h0208, 16'h0001);
    bus_write(16'h0206, 16'hFFFF);
  endtask

`ifdef RISC16_UART_EN
  task automatic test_uart_frame(input logic [7:0] b);
    bit fb [10];
    bit exp_tx, exp_busy;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
    fb[9] = 1'b1;
    set_bus(16'h020A, {8'h00, b}, 1'b1);
    tick();
    set_bus(16'h0208, 16'h0000, 1'b0);
    checks++;
    if (uart_tx !== 1'b1 || bus.rdata[3:2] !== 2'b00) begin
      errors++; $display("FAIL uart_push_edge got tx %b busy/empty %b exp tx 1 busy/empty 00", uart_tx, bus.rdata[3:2]);
    end
    for (int k = 1; k <= 10 * CPB + 1; k++) begin
      tick();
      exp_tx   = (k <= 10 * CPB) ? fb[(k - 1) / CPB] : 1'b1;
      exp_busy = (k <= 10 * CPB);
      checks++;
      if (uart_tx !== exp_tx || bus.rdata[3] !== exp_busy) begin
        errors++; $display("FAIL uart_frame byte %h k %0d got tx %b busy %b exp tx %b busy %b",
                           b, k, uart_tx, bus.rdata[3], exp_tx, exp_busy);
      end
    end
    checks++;
    if (bus.rdata[3:1] !== 3'b010) begin errors++; $display("FAIL uart_frame_end got %b exp 010", bus.rdata[3:1]); end
    $display("uart_frame: byte %h sent", b);
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] pushed [6];
    logic [7:0] got[$];
    int starts[$];
    bit stops[$];
    logic [7:0] v;
    int i;
    tx_log.delete();
    for (int p = 0; p < 6; p++) begin
      v = 8'($urandom);
      pushed[p] = v;
      set_bus(16'h020A, {8'h00, v}, 1'b1);
      tick();
    end
    set_bus(16'h0208, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata[3:1] !== 3'b101) begin errors++; $display("FAIL fifo_full_flag got %b exp 101", bus.rdata[3:1]); end
    for (int n = 0; n < 5 * (10 * CPB + 1) + 40; n++) tick();
    checks++;
    if (bus.rdata[3:1] !== 3'b010) begin errors++; $display("FAIL fifo_drained got %b exp 010", bus.rdata[3:1]); end
    i = 1;
    while (i < tx_log.size()) begin
      if (tx_log[i-1] == 1'b1 && tx_log[i] == 1'b0 && i + 10 * CPB <= tx_log.size()) begin
        for (int j = 0; j < 8; j++) v[j] = tx_log[i + (j + 1) * CPB + CPB / 2];
        got.push_back(v);
        starts.push_back(i);
        stops.push_back(tx_log[i + 9 * CPB + CPB / 2]);
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL fifo_frame_count got %0d exp 5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      checks++;
      if (got[k] !== pushed[k] || stops[k] !== 1'b1) begin
        errors++; $display("FAIL fifo_frame %0d got %h stop %b exp %h stop 1", k, got[k], stops[k], pushed[k]);
      end
      if (k > 0) begin
        checks++;
        if (starts[k] - starts[k-1] != 10 * CPB + 1) begin
          errors++; $display("FAIL fifo_spacing %0d got %0d exp %0d", k, starts[k] - starts[k-1], 10 * CPB + 1);
        end
      end
      $display("fifo: frame %0d byte %h at %0d", k, got[k], starts[k]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    bus_write(16'h0200, 16'h1234);
    for (int p = 0; p < 3; p++) bus_write(16'h020A, 16'($urandom));
    for (int n = 0; n < 2 * CPB + 2; n++) tick();
    rst = 1'b1;
    set_bus(16'h0208, 16'h0000, 1'b0);
    tick();
    checks++;
    if (uart_tx !== 1'b1 || bus.rdata !== 16'h0004 || led !== 24'h0) begin
      errors++; $display("FAIL rst_mid_frame got tx %b status %h led %h exp tx 1 status 0004 led 000000",
                         uart_tx, bus.rdata, led);
    end
    set_bus(16'h0204, 16'h0000, 1'b0);
    checks++;
    if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL rst_mid_timer got %h exp 0000", bus.rdata); end
    rst = 1'b0;
    set_bus(16'h0208, 16'h0000, 1'b0);
    tx_log.delete();
    for (int n = 0; n < 60; n++) tick();
    lows = 0;
    foreach (tx_log[k]) if (tx_log[k] == 1'b0) lows++;
    checks++;
    if (lows != 0 || bus.rdata[3:1] !== 3'b010) begin
      errors++; $display("FAIL rst_flush got low_samples %0d status %b exp 0 and 010", lows, bus.rdata[3:1]);
    end
    $display("reset_mid_frame: low samples after reset %0d", lows);
  endtask
`else
  task automatic test_uart_disabled();
    set_bus(16'h020A, 16'h0055, 1'b1);
    checks++;
    if (bus.hit !== 1'b0 || bus.rdata !== 16'h0000) begin
      errors++; $display("FAIL txdata_undecoded got hit %b rdata %h exp hit 0 rdata 0000", bus.hit, bus.rdata);
    end
    tick();
    set_bus(16'h0208, 16'h0000, 1'b0);
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (uart_tx !== 1'b1 || bus.rdata[3:1] !== 3'b010) begin
        errors++; $display("FAIL uart_tied got tx %b status %b exp tx 1 status 010", uart_tx, bus.rdata[3:1]);
      end
    end
    $display("uart_disabled: tx=%b", uart_tx);
  endtask
`endif

  initial begin
    rst = 1'b1;
    m_led = '0; m_timer = '0; m_cmp = 16'hFFFF; m_match = 1'b0;
    set_bus(16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_led();
    test_out_of_window();
    test_random_regs();
    test_timer_match();
`ifdef RISC16_UART_EN
    test_uart_frame(8'h55);
    test_uart_frame(8'($urandom));
    test_fifo_overflow();
    test_reset_mid_frame();
`else
    test_uart_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
